// File: rtl/suma_bcd_serie.sv
// Serial BCD adder: captures two 4-digit BCD operands on an add request, sums one
// digit per cycle (units first) and presents a registered 5-digit result with a strobe.
module suma_bcd_serie (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0][3:0] numero_sv,
  input  logic [3:0][3:0] numero,
  input  logic            suma,
  output logic [4:0][3:0] resultado,
  output logic            valido,
  output logic            ocupado,
  output logic            error,
  output logic            rst_sv,
  output logic [1:0]      dbg_estado_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } estado_t;

  estado_t         estado_q;
  logic [3:0][3:0] a_q;
  logic [3:0][3:0] b_q;
  logic [3:0][3:0] acc_q;
  logic            c_q;
  logic [1:0]      k_q;
  logic            err_op_q;
  logic [4:0][3:0] resultado_q;
  logic            valido_q;
  logic            ocupado_q;
  logic            error_q;
  logic            rst_sv_q;

  logic [4:0]      sum_d;
  logic [3:0]      digit_d;
  logic            carry_d;

  function automatic logic hay_no_bcd(input logic [3:0][3:0] x);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (x[i] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  // Digit k of the running sum; s > 9 wraps to s - 10, i.e. the low nibble of s + 6.
  always_comb begin
    sum_d   = {1'b0, a_q[k_q]} + {1'b0, b_q[k_q]} + {4'b0000, c_q};
    digit_d = sum_d[3:0];
    carry_d = 1'b0;
    if (sum_d > 5'd9) begin
      digit_d = sum_d[3:0] + 4'd6;
      carry_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      k_q         <= 2'd0;
      err_op_q    <= 1'b0;
      resultado_q <= '0;
      valido_q    <= 1'b0;
      ocupado_q   <= 1'b0;
      error_q     <= 1'b0;
      rst_sv_q    <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      rst_sv_q <= 1'b0;
      case (estado_q)
        IDLE: begin
          ocupado_q <= suma;
          if (suma) estado_q <= LOAD;
        end
        LOAD: begin
          a_q      <= numero_sv;
          b_q      <= numero;
          c_q      <= 1'b0;
          k_q      <= 2'd0;
          err_op_q <= hay_no_bcd(numero_sv) | hay_no_bcd(numero);
          estado_q <= ADD;
        end
        ADD: begin
          acc_q[k_q] <= digit_d;
          c_q        <= carry_d;
          k_q        <= k_q + 2'd1;
          if (k_q == 2'd3) estado_q <= DONE;
        end
        DONE: begin
          // ocupado stays high through the strobe cycle; IDLE decides whether it drops.
          resultado_q <= err_op_q ? '0 : {{3'b000, c_q}, acc_q};
          error_q     <= err_op_q;
          valido_q    <= 1'b1;
          rst_sv_q    <= 1'b1;
          estado_q    <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign resultado    = resultado_q;
  assign valido       = valido_q;
  assign ocupado      = ocupado_q;
  assign error        = error_q;
  assign rst_sv       = rst_sv_q;
  assign dbg_estado_o = estado_q;

endmodule

// File: tb/tb_suma_bcd_serie.sv
// Directed bench for suma_bcd_serie: hand-computed BCD sums, strobe timing,
// busy rejection, non-BCD error path and mid-operation reset.
module tb_suma_bcd_serie;

  logic            clk;
  logic            rst;
  logic [3:0][3:0] numero_sv;
  logic [3:0][3:0] numero;
  logic            suma;
  logic [4:0][3:0] resultado;
  logic            valido;
  logic            ocupado;
  logic            error;
  logic            rst_sv;
  logic [1:0]      dbg_estado;

  int checks = 0;
  int errors = 0;
  int nval;

  suma_bcd_serie dut (
    .clk          (clk),
    .rst          (rst),
    .numero_sv    (numero_sv),
    .numero       (numero),
    .suma         (suma),
    .resultado    (resultado),
    .valido       (valido),
    .ocupado      (ocupado),
    .error        (error),
    .rst_sv       (rst_sv),
    .dbg_estado_o (dbg_estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle 1ns so outputs are sampled away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full operation: suma at edge t, strobe expected after edge t+6 only, idle after t+7.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [19:0] exp_res, input logic exp_err);
    numero_sv = a;
    numero    = b;
    suma      = 1'b1;
    tick();
    suma = 1'b0;
    chk({tag, "_ocupado_t1"}, {19'd0, ocupado}, 20'd1);
    nval = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      nval += int'(valido) + int'(rst_sv);
    end
    chk({tag, "_early_strobe"}, nval, 20'd0);
    tick();
    chk({tag, "_valido"},    {19'd0, valido},  20'd1);
    chk({tag, "_rst_sv"},    {19'd0, rst_sv},  20'd1);
    chk({tag, "_resultado"}, resultado,        exp_res);
    chk({tag, "_error"},     {19'd0, error},   {19'd0, exp_err});
    tick();
    chk({tag, "_valido_w1"}, {19'd0, valido},  20'd0);
    chk({tag, "_ocupado_end"}, {19'd0, ocupado}, 20'd0);
    chk({tag, "_hold"},      resultado,        exp_res);
  endtask

  initial begin
    rst       = 1'b1;
    suma      = 1'b0;
    numero_sv = '0;
    numero    = '0;
    tick();
    tick();
    chk("reset_resultado", resultado, 20'h00000);
    chk("reset_flags", {15'd0, valido, ocupado, error, rst_sv, 1'b0}, 20'd0);
    rst = 1'b0;
    tick();

    run_op("basic", 16'h1234, 16'h4321, 20'h05555, 1'b0);
    run_op("max",   16'h9999, 16'h9999, 20'h19998, 1'b0);
    run_op("ripple",16'h0999, 16'h0001, 20'h01000, 1'b0);
    run_op("zero",  16'h0000, 16'h0000, 20'h00000, 1'b0);

    // Busy reject: extra pulses at t+3 and t+6 are ignored; t+7 starts a new op.
    numero_sv = 16'h0005;
    numero    = 16'h0007;
    suma      = 1'b1;
    tick();
    nval = 0;
    for (int c = 1; c <= 6; c++) begin
      suma = (c == 3 || c == 6);
      tick();
      nval += int'(valido);
    end
    chk("busy_one_valido", nval, 20'd1);
    chk("busy_resultado", resultado, 20'h00012);
    numero_sv = 16'h0010;
    numero    = 16'h0020;
    suma      = 1'b1;
    tick();
    suma = 1'b0;
    chk("busy_restart_ocupado", {19'd0, ocupado}, 20'd1);
    chk("busy_restart_valido",  {19'd0, valido},  20'd0);
    nval = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      nval += int'(valido);
    end
    chk("busy_restart_early", nval, 20'd0);
    tick();
    chk("busy_restart_valido6", {19'd0, valido}, 20'd1);
    chk("busy_restart_res", resultado, 20'h00030);
    tick();

    run_op("nonbcd", 16'h00A0, 16'h0001, 20'h00000, 1'b1);
    run_op("after_err", 16'h0002, 16'h0003, 20'h00005, 1'b0);

    // Reset at t+3 aborts 1111+2222.
    numero_sv = 16'h1111;
    numero    = 16'h2222;
    suma      = 1'b1;
    tick();
    suma = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_resultado", resultado, 20'h00000);
    chk("rst_mid_flags", {16'd0, valido, ocupado, error, rst_sv}, 20'd0);
    nval = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      nval += int'(valido) + int'(rst_sv) + int'(ocupado);
    end
    chk("rst_mid_quiet", nval, 20'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 20'h00002, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/suma_bcd_serie.md
# suma_bcd_serie

Sequential BCD adder on the consumer side of the operand-capture stage. It samples the stored operand `numero_sv` and the live keypad entry `numero` when `suma` pulses, then adds them one digit per cycle, least-significant digit first. It presents a 5-digit BCD result with a one-cycle valid strobe and issues a one-cycle `rst_sv` pulse that clears the capture stage for the next operation.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — clock; all logic on the rising edge.
- `rst` — input, 1 — reset, synchronous, active-high.
- `numero_sv` — input, [3:0][3:0] — stored operand A, four BCD digits, index 0 = units.
- `numero` — input, [3:0][3:0] — current entry B, four BCD digits, index 0 = units.
- `suma` — input, 1 — add request, single-cycle pulse from the capture stage.
- `resultado` — output, [4:0][3:0] — sum, five BCD digits, index 0 = units, index 4 = final carry (0 or 1).
- `valido` — output, 1 — one-cycle strobe; `resultado` is updated in that same cycle.
- `ocupado` — output, 1 — high from LOAD through DONE inclusive.
- `error` — output, 1 — last accepted operation contained a non-BCD digit.
- `rst_sv` — output, 1 — one-cycle clear pulse to the capture stage, coincident with `valido`.

## Operation
- FSM states:
  - IDLE → LOAD when `suma`=1.
  - LOAD → ADD, which always lasts exactly 4 cycles, indexed by digit counter `k` = 0..3.
  - ADD → DONE after digit 3.
  - DONE → IDLE unconditionally.
- IDLE:
  - `ocupado`=0.
  - `suma` is the only event that starts an operation.
- LOAD:
  - Register A=`numero_sv` and B=`numero`.
  - Clear the carry and `k`.
  - Set `error`=1 if any of the 8 digits > 9; otherwise set `error`=0.
- ADD, cycle k:
  - Compute s = A[k] + B[k] + c, 5-bit, range 0..19.
  - If s > 9: digit = s − 10 (low nibble of s + 6), c = 1.
  - Otherwise: digit = s, c = 0.
  - Write the digit into the internal accumulator slot k.
- DONE:
  - `resultado` ← {c, acc[3], acc[2], acc[1], acc[0]}.
  - If `error`=1, `resultado` ← 0.
  - `valido`=1 and `rst_sv`=1 for this cycle only.
- `resultado` and `error` hold their values until the next DONE or `rst`. The accumulator is internal and never visible mid-operation.
- `suma` while `ocupado`=1 is ignored and not queued.
- `suma` arriving in the DONE cycle is ignored.
- A and B are registered at LOAD; input changes during ADD have no effect.
- Error path: an operation with a non-BCD digit still runs the full length and still pulses `valido` and `rst_sv`, so the capture stage is always cleared.

## Timing
- Reset (`rst`=1 at an edge):
  - `resultado`=0, `valido`=0, `ocupado`=0, `error`=0, `rst_sv`=0.
  - FSM = IDLE, carry = 0, `k` = 0, accumulator = 0.
- Reset takes priority in every state. Reset mid-ADD aborts the operation: no `valido`, no `rst_sv`.
- Latency: `suma` sampled high at edge t.
  - t+1: LOAD, `ocupado` goes high.
  - t+2..t+5: ADD, digits 0..3.
  - t+6: DONE; `valido`, `rst_sv` and the new `resultado` are visible after that edge.
  - t+7: IDLE, `ocupado`=0.
- Throughput: one operation per 7 cycles. The next `suma` is accepted at the edge where the FSM is in IDLE.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic add:
  - A=1234, B=4321, pulse `suma`.
  - Expect `resultado`=0_5555.
  - `valido` and `rst_sv` high exactly 6 cycles after the `suma` edge, width 1.
  - `error`=0.
- Maximum value: A=9999, B=9999 → `resultado`=1_9998.
- Carry ripple and zero operand:
  - A=0999, B=0001 → `resultado`=0_1000.
  - A=0000, B=0000 → `resultado`=0_0000 and `valido` still pulses.
- Busy reject:
  - A=0005, B=0007, `suma` at t, then extra `suma` pulses at t+3 and t+6.
  - Expect exactly one `valido`, with `resultado`=0_0012.
  - A `suma` at t+7 starts a new operation.
- Invalid digit:
  - A = digits {0,0,A,0} (hex 0x00A0), B=0001.
  - Expect `error`=1, `resultado`=0, `valido`=1, `rst_sv`=1.
  - A following valid 0002+0003 gives `error`=0 and `resultado`=0_0005.
- Reset mid-operation:
  - Start 1111+2222, assert `rst` at t+3.
  - Expect no `valido` or `rst_sv`; all outputs 0; `ocupado`=0 on the next cycle.
  - A fresh 0001+0001 then yields 0_0002.
